// File: rtl/rv32i_decode_stage.sv
// rv32i_decode_stage: registered RV32I / RV32E decode stage with valid/ready flow control.
// Decodes register addresses, ALU operation, immediate, opcode, funct3 and an illegal flag
// into a pipeline register toward execute.
// Optional feature macro: DECODE_SKID_BUF_EN adds a one-entry skid register behind the
// output register (capacity 2, o_ready driven from a flop). Without it capacity is 1 and
// o_ready = !o_valid || i_ready.
module rv32i_decode_stage #(
    parameter int REG_ADDR_W = 5,
    parameter int PC_W       = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [31:0]           i_inst,
    input  logic [PC_W-1:0]       i_pc,
    input  logic                  i_flush,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [PC_W-1:0]       o_pc,
    output logic [REG_ADDR_W-1:0] o_rs1_addr,
    output logic [REG_ADDR_W-1:0] o_rs2_addr,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic [6:0]            o_opcode,
    output logic [2:0]            o_funct3,
    output logic [3:0]            o_op,
    output logic [31:0]           o_imm,
    output logic                  o_illegal
);

    // Handshake: an instruction moves in when i_valid && o_ready at a rising edge and
    // moves out when o_valid && i_ready at a rising edge. Once o_valid is high the
    // presented fields stay stable until the transfer out completes (or a flush/reset).

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;
    localparam logic [3:0] ALU_NEQ  = 4'd11;
    localparam logic [3:0] ALU_GE   = 4'd12;
    localparam logic [3:0] ALU_GEU  = 4'd13;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [PC_W-1:0]       pc;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [6:0]            opcode;
        logic [2:0]            funct3;
        logic [3:0]            op;
        logic [31:0]           imm;
        logic                  illegal;
    } dec_t;

    // ALU operation shared by OP and OP-IMM; alt is inst[30], SUB only exists for OP.
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt,
                                            input logic is_reg);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;

    assign opc   = i_inst[6:0];
    assign f3    = i_inst[14:12];
    assign f7    = i_inst[31:25];
    assign imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
    assign imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
    assign imm_u = {i_inst[31:12], 12'h000};

    logic [3:0]  op_raw;
    logic [31:0] imm_raw;
    logic        bad;
    logic        use_rd;
    logic        use_rs1;
    logic        use_rs2;
    dec_t        dec_in;

    // Combinational decode of the incoming instruction: operation, immediate, legality
    // and which register fields the format actually uses (needed for the RV32E check).
    // SYSTEM immediate forms (funct3[2]=1) carry a uimm in the rs1 field, so only rd counts.
    always_comb begin
        op_raw  = ALU_ADD;
        imm_raw = '0;
        bad     = (i_inst[1:0] != 2'b11);
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opc)
            OPC_OP: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                op_raw  = arith_op(f3, i_inst[30], 1'b1);
                if (f7 == F7_ALT) begin
                    if (f3 != 3'b000 && f3 != 3'b101) bad = 1'b1;
                end else if (f7 != F7_ZERO) begin
                    bad = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                op_raw  = arith_op(f3, i_inst[30], 1'b0);
                imm_raw = imm_i;
                if (f3 == 3'b001 && f7 != F7_ZERO) bad = 1'b1;
                if (f3 == 3'b101 && f7 != F7_ZERO && f7 != F7_ALT) bad = 1'b1;
            end
            OPC_LOAD: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm_raw = imm_i;
                if (f3 == 3'b011 || f3[2:1] == 2'b11) bad = 1'b1;
            end
            OPC_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_raw = imm_s;
                if (f3 > 3'b010) bad = 1'b1;
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_raw = imm_b;
                case (f3)
                    3'b000:  op_raw = ALU_EQ;
                    3'b001:  op_raw = ALU_NEQ;
                    3'b100:  op_raw = ALU_SLT;
                    3'b101:  op_raw = ALU_GE;
                    3'b110:  op_raw = ALU_SLTU;
                    3'b111:  op_raw = ALU_GEU;
                    default: bad    = 1'b1;
                endcase
            end
            OPC_JAL: begin
                use_rd  = 1'b1;
                imm_raw = imm_j;
            end
            OPC_JALR: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm_raw = imm_i;
                if (f3 != 3'b000) bad = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                use_rd  = 1'b1;
                imm_raw = imm_u;
            end
            OPC_SYSTEM: begin
                use_rd  = 1'b1;
                use_rs1 = !f3[2];
            end
            OPC_MISC_MEM: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (REG_ADDR_W == 4) begin
            if ((use_rd && i_inst[11]) || (use_rs1 && i_inst[19]) || (use_rs2 && i_inst[24]))
                bad = 1'b1;
        end
    end

    // Assemble the decoded record; illegal instructions carry a neutral op and immediate.
    always_comb begin
        dec_in         = '0;
        dec_in.pc      = i_pc;
        dec_in.rs1     = i_inst[15 +: REG_ADDR_W];
        dec_in.rs2     = i_inst[20 +: REG_ADDR_W];
        dec_in.rd      = i_inst[7 +: REG_ADDR_W];
        dec_in.opcode  = opc;
        dec_in.funct3  = f3;
        dec_in.op      = bad ? ALU_ADD : op_raw;
        dec_in.imm     = bad ? 32'h0 : imm_raw;
        dec_in.illegal = bad;
    end

    logic in_fire;
    logic valid_q;
    logic valid_d;
    dec_t out_q;
    dec_t out_d;

    assign in_fire = i_valid && o_ready;

`ifdef DECODE_SKID_BUF_EN
    logic skid_valid_q;
    logic skid_valid_d;
    dec_t skid_q;
    dec_t skid_d;
    logic ready_q;

    // Output register refills from the skid entry first; new input lands in the skid
    // entry only while the output is stalled. Flush drops both entries.
    always_comb begin
        valid_d      = valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (i_flush) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!valid_q || i_ready) begin
            if (skid_valid_q) begin
                valid_d      = 1'b1;
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                valid_d = in_fire;
                if (in_fire) out_d = dec_in;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_d       = dec_in;
        end
    end

    // Pipeline and skid registers; o_ready is registered from the next skid occupancy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q      <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            ready_q      <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            ready_q      <= !skid_valid_d;
        end
    end

    assign o_ready = ready_q;
`else
    logic alive_q;

    // Single output register: it advances whenever it is empty or being drained.
    always_comb begin
        valid_d = valid_q;
        out_d   = out_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (!valid_q || i_ready) begin
            valid_d = in_fire;
            if (in_fire) out_d = dec_in;
        end
    end

    // Pipeline register; alive_q keeps o_ready low until the first edge after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            out_q   <= '0;
            alive_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            out_q   <= out_d;
            alive_q <= 1'b1;
        end
    end

    assign o_ready = alive_q && (!valid_q || i_ready);
`endif

    assign o_valid    = valid_q;
    assign o_pc       = out_q.pc;
    assign o_rs1_addr = out_q.rs1;
    assign o_rs2_addr = out_q.rs2;
    assign o_rd_addr  = out_q.rd;
    assign o_opcode   = out_q.opcode;
    assign o_funct3   = out_q.funct3;
    assign o_op       = out_q.op;
    assign o_imm      = out_q.imm;
    assign o_illegal  = out_q.illegal;

endmodule
